// File: rtl/spgd_step_if.sv
// Signal bundle between the SPGD step controller and its surroundings:
// run control, averager handshake and the packed DAC bus.
interface spgd_step_if #(
  parameter int ADC_WIDTH  = 12,
  parameter int DAC_WIDTH  = 12,
  parameter int NUM_CH     = 4,
  parameter int PERT_WIDTH = 8
);
  logic                          EN;
  logic [PERT_WIDTH-1:0]         AMP;
  logic [7:0]                    GAIN;
  logic signed [ADC_WIDTH-1:0]   METRIC_IN;
  logic                          METRIC_VALID;
  logic                          AVG_RST;
  logic [NUM_CH*DAC_WIDTH-1:0]   DAC_OUT;
  logic                          DAC_STROBE;
  logic                          ITER_DONE;
  logic [31:0]                   ITER_COUNT;
  logic                          BUSY;

  modport master (
    output EN, AMP, GAIN, METRIC_IN, METRIC_VALID,
    input  AVG_RST, DAC_OUT, DAC_STROBE, ITER_DONE, ITER_COUNT, BUSY
  );

  modport slave (
    input  EN, AMP, GAIN, METRIC_IN, METRIC_VALID,
    output AVG_RST, DAC_OUT, DAC_STROBE, ITER_DONE, ITER_COUNT, BUSY
  );
endinterface

// File: rtl/spgd_step.sv
// One SPGD iteration per EN: perturb +/-, settle with the averager held in
// reset, capture one metric per polarity, then step the channel bases.
module spgd_step #(
  parameter int          ADC_WIDTH     = 12,
  parameter int          DAC_WIDTH     = 12,
  parameter int          NUM_CH        = 4,
  parameter int          PERT_WIDTH    = 8,
  parameter int          GAIN_SHIFT    = 4,
  parameter int          SETTLE_CYCLES = 64,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input logic       CLK,
  input logic       RST,
  spgd_step_if.slave bus
);

  localparam int W  = DAC_WIDTH + ADC_WIDTH + PERT_WIDTH + 10;
  localparam int CW = $clog2(SETTLE_CYCLES + 2);
  localparam logic [DAC_WIDTH-1:0] MID  = {1'b1, {(DAC_WIDTH-1){1'b0}}};
  localparam logic [DAC_WIDTH-1:0] DMAX = {DAC_WIDTH{1'b1}};
  localparam logic [CW-1:0]        SETTLE_INIT = CW'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    IDLE, APPLY_P, SETTLE_P, MEAS_P, APPLY_M, SETTLE_M, MEAS_M, UPDATE
  } state_e;

  // Adds a signed offset to an unsigned DAC word and clamps to the DAC range.
  function automatic logic [DAC_WIDTH-1:0] sat_add(
    input logic [DAC_WIDTH-1:0] base,
    input logic signed [W-1:0]  off
  );
    logic signed [W-1:0] sum;
    sum = $signed({{(W-DAC_WIDTH){1'b0}}, base}) + off;
    if (sum[W-1])
      sat_add = {DAC_WIDTH{1'b0}};
    else if (sum > $signed({{(W-DAC_WIDTH){1'b0}}, DMAX}))
      sat_add = DMAX;
    else
      sat_add = sum[DAC_WIDTH-1:0];
  endfunction

  state_e                             state_q, state_d;
  logic [15:0]                        lfsr_q, lfsr_d;
  logic [NUM_CH-1:0]                  signs_q, signs_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic signed [ADC_WIDTH-1:0]        jp_q, jp_d, jm_q, jm_d;
  logic [NUM_CH-1:0][DAC_WIDTH-1:0]   base_q, base_d, dac_q, dac_d;
  logic                               avg_rst_q, avg_rst_d;
  logic                               strobe_q, strobe_d;
  logic                               done_q, done_d;
  logic                               busy_q, busy_d;
  logic [31:0]                        count_q, count_d;

  logic signed [W-1:0] amp_s, dj_s, prod_s, delta_s;
  logic                fb_s;

  assign fb_s    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign amp_s   = $signed({{(W-PERT_WIDTH){1'b0}}, bus.AMP});
  assign dj_s    = $signed({{(W-ADC_WIDTH){jp_q[ADC_WIDTH-1]}}, jp_q})
                 - $signed({{(W-ADC_WIDTH){jm_q[ADC_WIDTH-1]}}, jm_q});
  assign prod_s  = dj_s * $signed({{(W-8){1'b0}}, bus.GAIN});
  assign delta_s = prod_s >>> GAIN_SHIFT;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    signs_d  = signs_q;
    cnt_d    = cnt_q;
    jp_d     = jp_q;
    jm_d     = jm_q;
    base_d   = base_q;
    dac_d    = dac_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (bus.EN) begin
          signs_d = lfsr_q[NUM_CH-1:0];
          lfsr_d  = {lfsr_q[14:0], fb_s};
          state_d = APPLY_P;
        end else begin
          state_d = IDLE;
        end
      end
      APPLY_P, APPLY_M: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (signs_q[i] == (state_q == APPLY_P))
            dac_d[i] = sat_add(base_q[i], amp_s);
          else
            dac_d[i] = sat_add(base_q[i], -amp_s);
        end
        strobe_d = 1'b1;
        cnt_d    = SETTLE_INIT;
        state_d  = (state_q == APPLY_P) ? SETTLE_P : SETTLE_M;
      end
      SETTLE_P, SETTLE_M: begin
        cnt_d = (cnt_q == {CW{1'b0}}) ? {CW{1'b0}} : cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q <= {{(CW-1){1'b0}}, 1'b1})
          state_d = (state_q == SETTLE_P) ? MEAS_P : MEAS_M;
        else
          state_d = state_q;
      end
      MEAS_P: begin
        if (bus.METRIC_VALID) begin
          jp_d    = bus.METRIC_IN;
          state_d = APPLY_M;
        end else begin
          state_d = MEAS_P;
        end
      end
      MEAS_M: begin
        if (bus.METRIC_VALID) begin
          jm_d    = bus.METRIC_IN;
          state_d = UPDATE;
        end else begin
          state_d = MEAS_M;
        end
      end
      UPDATE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (signs_q[i])
            base_d[i] = sat_add(base_q[i], delta_s);
          else
            base_d[i] = sat_add(base_q[i], -delta_s);
        end
        dac_d    = base_d;
        strobe_d = 1'b1;
        done_d   = 1'b1;
        count_d  = count_q + 32'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // The averager runs only while a metric is being awaited.
    avg_rst_d = !((state_d == MEAS_P) || (state_d == MEAS_M));
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      signs_q   <= {NUM_CH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      jp_q      <= {ADC_WIDTH{1'b0}};
      jm_q      <= {ADC_WIDTH{1'b0}};
      base_q    <= {NUM_CH{MID}};
      dac_q     <= {NUM_CH{MID}};
      avg_rst_q <= 1'b1;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      signs_q   <= signs_d;
      cnt_q     <= cnt_d;
      jp_q      <= jp_d;
      jm_q      <= jm_d;
      base_q    <= base_d;
      dac_q     <= dac_d;
      avg_rst_q <= avg_rst_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign bus.AVG_RST    = avg_rst_q;
  assign bus.DAC_OUT    = dac_q;
  assign bus.DAC_STROBE = strobe_q;
  assign bus.ITER_DONE  = done_q;
  assign bus.ITER_COUNT = count_q;
  assign bus.BUSY       = busy_q;

endmodule

// File: tb/tb_spgd_step.sv
// Directed bench for spgd_step: vector table of single iterations from reset
// plus hand-written sequences for saturation chaining, stray pulses and resets.
module tb_spgd_step;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spgd_step_if #(.ADC_WIDTH(12), .DAC_WIDTH(12), .NUM_CH(4), .PERT_WIDTH(8)) bus ();

  spgd_step #(
    .ADC_WIDTH(12), .DAC_WIDTH(12), .NUM_CH(4), .PERT_WIDTH(8),
    .GAIN_SHIFT(4), .SETTLE_CYCLES(64), .LFSR_SEED(16'hACE1)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]          amp;
    logic [7:0]          gain;
    logic signed [11:0]  jp;
    logic signed [11:0]  jm;
    logic [47:0]         exp_p;
    logic [47:0]         exp_m;
    logic [47:0]         exp_u;
  } vec_t;

  vec_t vecs[6];
  vec_t v_sat2;

  function automatic logic [47:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {c3[11:0], c2[11:0], c1[11:0], c0[11:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.EN = 1'b0;
    bus.METRIC_VALID = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " dac"},     64'(bus.DAC_OUT), 64'(pk(2048, 2048, 2048, 2048)));
    check({tag, " avg_rst"}, 64'(bus.AVG_RST), 64'd1);
    check({tag, " busy"},    64'(bus.BUSY), 64'd0);
    check({tag, " count"},   64'(bus.ITER_COUNT), 64'd0);
    check({tag, " strobe"},  64'(bus.DAC_STROBE), 64'd0);
    check({tag, " done"},    64'(bus.ITER_DONE), 64'd0);
  endtask

  // Runs from APPLY_x until the DUT sits in MEAS_x, checking settle length and strobe.
  task automatic phase(input logic [47:0] exp_dac, input bit stray, input string tag);
    int hi = 0;
    int nstb = 0;
    int n = 0;
    logic [47:0] seen = '0;
    while (n < 400 && !(bus.BUSY && !bus.AVG_RST)) begin
      if (bus.BUSY && bus.AVG_RST) hi++;
      if (bus.DAC_STROBE) begin
        nstb++;
        seen = bus.DAC_OUT;
      end
      if (stray && hi == 10) begin
        bus.METRIC_IN = 12'sd999;
        bus.METRIC_VALID = 1'b1;
      end else begin
        bus.METRIC_VALID = 1'b0;
      end
      tick();
      n++;
    end
    bus.METRIC_VALID = 1'b0;
    check({tag, " reach meas"}, 64'(n < 400), 64'd1);
    check({tag, " avg_rst len"}, 64'(hi), 64'd65);
    check({tag, " strobe cnt"}, 64'(nstb), 64'd1);
    check({tag, " dac"}, 64'(seen), 64'(exp_dac));
  endtask

  task automatic pulse(input logic signed [11:0] val);
    bus.METRIC_IN = val;
    bus.METRIC_VALID = 1'b1;
    tick();
    bus.METRIC_VALID = 1'b0;
  endtask

  task automatic run_iter(input vec_t v, input bit stray, input bit hold_en,
                          input logic [31:0] exp_cnt, input string tag);
    bus.AMP  = v.amp;
    bus.GAIN = v.gain;
    bus.EN   = 1'b1;
    tick();
    if (!hold_en) bus.EN = 1'b0;
    phase(v.exp_p, stray, {tag, "+"});
    bus.EN = 1'b0;
    pulse(v.jp);
    phase(v.exp_m, 1'b0, {tag, "-"});
    pulse(v.jm);
    tick();
    check({tag, " done"},   64'(bus.ITER_DONE), 64'd1);
    check({tag, " update"}, 64'(bus.DAC_OUT), 64'(v.exp_u));
    check({tag, " ustrobe"}, 64'(bus.DAC_STROBE), 64'd1);
    check({tag, " count"},  64'(bus.ITER_COUNT), 64'(exp_cnt));
    check({tag, " busy"},   64'(bus.BUSY), 64'd0);
    tick();
    check({tag, " done width"}, 64'(bus.ITER_DONE), 64'd0);
  endtask

  initial begin
    int ev;

    vecs[0] = '{8'd10,  8'd16,  12'sd100,   12'sd40,
                pk(2058, 2038, 2038, 2038), pk(2038, 2058, 2058, 2058), pk(2108, 1988, 1988, 1988)};
    vecs[1] = '{8'd0,   8'd1,   -12'sd5,    12'sd0,
                pk(2048, 2048, 2048, 2048), pk(2048, 2048, 2048, 2048), pk(2047, 2049, 2049, 2049)};
    vecs[2] = '{8'd255, 8'd255, 12'sd2047,  -12'sd2048,
                pk(2303, 1793, 1793, 1793), pk(1793, 2303, 2303, 2303), pk(4095, 0, 0, 0)};
    vecs[3] = '{8'd100, 8'd3,   -12'sd1000, 12'sd1000,
                pk(2148, 1948, 1948, 1948), pk(1948, 2148, 2148, 2148), pk(1673, 2423, 2423, 2423)};
    vecs[4] = '{8'd7,   8'd5,   12'sd3,     12'sd0,
                pk(2055, 2041, 2041, 2041), pk(2041, 2055, 2055, 2055), pk(2048, 2048, 2048, 2048)};
    vecs[5] = '{8'd1,   8'd1,   12'sd0,     12'sd1,
                pk(2049, 2047, 2047, 2047), pk(2047, 2049, 2049, 2049), pk(2047, 2049, 2049, 2049)};
    // Second iteration after saturation: signs from 0x59C3 (ch0,ch1 +; ch2,ch3 -).
    v_sat2  = '{8'd255, 8'd16,  12'sd0,     12'sd0,
                pk(4095, 255, 0, 0), pk(3840, 0, 255, 255), pk(4095, 0, 0, 0)};

    bus.EN = 1'b0;
    bus.AMP = 8'd0;
    bus.GAIN = 8'd0;
    bus.METRIC_IN = 12'sd0;
    bus.METRIC_VALID = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_reset("por");
    rst = 1'b0;
    ev = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.DAC_STROBE || bus.BUSY || !bus.AVG_RST ||
          bus.DAC_OUT != pk(2048, 2048, 2048, 2048)) ev++;
    end
    check("idle quiet", 64'(ev), 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_iter(vecs[i], 1'b0, 1'b0, 32'd1, $sformatf("v%0d", i));
    end

    do_reset();
    run_iter(vecs[2], 1'b0, 1'b0, 32'd1, "sat1");
    run_iter(v_sat2, 1'b0, 1'b0, 32'd2, "sat2");

    // Third iteration abandoned by RST while waiting for the minus metric.
    bus.AMP = 8'd0;
    bus.EN = 1'b1;
    tick();
    bus.EN = 1'b0;
    phase(pk(4095, 0, 0, 0), 1'b0, "abort+");
    pulse(12'sd5);
    phase(pk(4095, 0, 0, 0), 1'b0, "abort-");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rst meas_m");

    do_reset();
    run_iter(vecs[0], 1'b1, 1'b0, 32'd1, "stray");

    do_reset();
    run_iter(vecs[0], 1'b0, 1'b1, 32'd1, "endrop");
    ev = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.ITER_DONE || bus.BUSY || bus.DAC_STROBE) ev++;
    end
    check("endrop stays idle", 64'(ev), 64'd0);
    check("endrop count", 64'(bus.ITER_COUNT), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spgd_step.md
Name: spgd_step

Overview:
- Downstream consumer of the ADC averaging stage. Runs one stochastic parallel gradient descent (SPGD) loop over NUM_CH DAC control channels.
- Each iteration:
  - applies +perturbation, then −perturbation, to all channels;
  - holds the averager in reset while the DAC settles;
  - captures one averaged metric per polarity;
  - updates the channel base values by the gain-scaled metric difference.
- AVG_RST drives the averager's RST. The averager's completion, converted to a one-cycle pulse, drives METRIC_VALID.

Parameters:
ADC_WIDTH, 12, width of signed averaged metric
DAC_WIDTH, 12, width of each unsigned DAC channel word
NUM_CH, 4, number of control channels (max 16)
PERT_WIDTH, 8, width of perturbation amplitude
GAIN_SHIFT, 4, right arithmetic shift applied after gain multiply
SETTLE_CYCLES, 64, DAC settle cycles with averager held in reset
LFSR_SEED, 16'hACE1, nonzero reset value of perturbation-sign LFSR

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
EN  in  1  start/continue iterations; sampled only in IDLE
AMP  in  PERT_WIDTH  unsigned perturbation amplitude (DAC LSBs)
GAIN  in  8  unsigned update gain
METRIC_IN  in  ADC_WIDTH  signed averaged metric
METRIC_VALID  in  1  one-cycle pulse: METRIC_IN valid
AVG_RST  out  1  reset to averager; high while settling
DAC_OUT  out  NUM_CH*DAC_WIDTH  packed channel words, ch0 in LSBs
DAC_STROBE  out  1  one-cycle pulse on every DAC_OUT change
ITER_DONE  out  1  one-cycle pulse at end of each update
ITER_COUNT  out  32  completed iterations, wraps at 2^32
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state IDLE; LFSR=LFSR_SEED;
  - every base=2^(DAC_WIDTH-1), DAC_OUT=all bases;
  - AVG_RST=1; DAC_STROBE=ITER_DONE=BUSY=0; ITER_COUNT=0; J+=J-=0.
- RST asserted in any state returns every output to reset values on the next edge. Any in-flight iteration is discarded; bases return to midscale.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifted left with feedback into bit0. Advances exactly once per iteration, in IDLE on leaving.
- Sign s_i = +1 if LFSR bit i = 1, else −1. Latched from the pre-advance LFSR value.
- States (all outputs registered):
  - IDLE: AVG_RST=1. If EN: latch signs, advance LFSR -> APPLY_P; else stay.
  - APPLY_P (1 cycle): DAC_OUT_i=sat(base_i + s_i*AMP); DAC_STROBE=1; settle counter=SETTLE_CYCLES -> SETTLE_P.
  - SETTLE_P: AVG_RST=1; counter decrements each cycle. Leave on the cycle it reaches 0 -> MEAS_P. AVG_RST is high exactly SETTLE_CYCLES+1 cycles counting APPLY_P.
  - MEAS_P: AVG_RST=0. Wait for METRIC_VALID; capture J+=METRIC_IN -> APPLY_M.
  - APPLY_M / SETTLE_M / MEAS_M: mirror of the + phases with DAC_OUT_i=sat(base_i − s_i*AMP); capture J− -> UPDATE.
  - UPDATE (1 cycle):
    - dJ = J+ − J− (ADC_WIDTH+1 bits signed).
    - delta = (dJ*GAIN) >>> GAIN_SHIFT. Full-width signed product; arithmetic shift rounds toward −inf.
    - base_i = sat(base_i + s_i*delta); DAC_OUT=new bases; DAC_STROBE=1; ITER_DONE=1; ITER_COUNT+=1 -> IDLE.
- sat(): clamp to [0, 2^DAC_WIDTH−1]. Compute in ≥DAC_WIDTH+ADC_WIDTH+10 signed bits so no intermediate wraps.
- METRIC_VALID outside MEAS_P/MEAS_M is ignored. Pulses arriving while AVG_RST is high are never captured.
- EN is not sampled mid-iteration: dropping EN lets the current iteration finish, then the block stays in IDLE.
- AMP and GAIN are sampled at use (APPLY_*, UPDATE). Changing them mid-iteration is permitted.
- No timeout: MEAS states wait indefinitely; RST is the only exit.

Test Plan:
- Reset: RST high 3 cycles -> DAC_OUT every channel 2048, AVG_RST=1, BUSY=0, ITER_COUNT=0. After release with EN=0 for 100 cycles -> state/outputs unchanged, no DAC_STROBE.
- Perturbation (defaults, AMP=10): EN=1 -> signs from 0xACE1 (bits3:0=0001).
  - APPLY_P: ch0=2058, ch1..3=2038, DAC_STROBE one cycle.
  - AVG_RST high exactly 65 cycles.
  - APPLY_M: ch0=2038, ch1..3=2058.
- Update: GAIN=16, GAIN_SHIFT=4, J+=100, J−=40 -> DAC_OUT ch0=2108, ch1..3=1988, ITER_DONE one cycle, ITER_COUNT=1, BUSY=0.
- Rounding/negative: GAIN=1, GAIN_SHIFT=1, J+=−5, J−=0 -> delta=−3. ch0=2045, ch1..3=2051.
- Saturation: GAIN=255, GAIN_SHIFT=0, J+=2047, J−=−2048 -> ch0=4095, ch1..3=0. Next iteration with AMP=255 -> perturbed ch0 clamps at 4095/0 accordingly, no wrap.
- Robustness:
  - METRIC_VALID pulse during SETTLE_P is ignored; the block waits for the next pulse.
  - RST asserted in MEAS_M -> next cycle all outputs at reset values.
  - EN dropped mid-iteration -> exactly one ITER_DONE, then IDLE.
